fetch_unit: RTL

Prefetching instruction fetch unit sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues one 16-bit instruction read at a time to a variable-latency instruction memory. Returned words are buffered, each with its PC+2, in a small queue that drains into decode under a ready handshake. Branch/jump redirects flush the queue and discard any in-flight response.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/fetch_unit.sv | 89 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
package fetch_pkg;
    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;
    localparam logic [PC_W-1:0] PC_STEP = 16'd2;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc_next;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_STEP;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue with flush; head reads as zero while empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  fetch_entry_t               i_data,
    input  logic                       i_pop,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          w_empty, w_full, w_push, w_pop;

    assign w_empty = r_count == '0;
    assign w_full  = r_count == CW'(DEPTH);
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_head  = w_empty ? '0 : r_mem[r_rptr];
    assign o_count = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_push);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end

    always_ff @(posedge clk)
        if (w_push && !i_flush)
            r_mem[r_wptr] <= i_data;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: prefetching fetch unit, one outstanding read, flushable queue into decode.
// Define FETCH_BYPASS_EN to forward an ack straight to decode when the queue is empty.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc_next,
    input  logic               id_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_fpc, r_drop_addr;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_next_count;
    logic            w_ack, w_take, w_push, w_pop, w_room, w_empty;
    fetch_entry_t    w_head, w_new;

    assign mem_req      = r_state != IDLE;
    assign mem_addr     = r_state == DROP ? r_drop_addr : r_fpc;
    assign w_ack        = mem_ack && mem_req;
    assign w_take       = w_ack && r_state == WAIT && !redirect_valid;
    assign w_new        = {pc_inc(r_fpc), mem_rdata};
    assign w_empty      = w_count == '0;
    assign w_pop        = !w_empty && id_ready && !redirect_valid;
    assign w_next_count = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
    assign w_room       = w_next_count < (CW+1)'(DEPTH);

`ifdef FETCH_BYPASS_EN
    logic w_byp;
    assign w_byp                  = w_empty && w_take;
    assign w_push                 = w_take && !(w_byp && id_ready);
    assign if_valid               = !w_empty || w_byp;
    assign {if_pc_next, if_instr} = w_byp ? w_new : w_head;
`else
    assign w_push                 = w_take;
    assign if_valid               = !w_empty;
    assign {if_pc_next, if_instr} = w_head;
`endif

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_new),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // DROP keeps presenting the abandoned address until its ack arrives.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state     <= IDLE;
            r_fpc       <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else if (redirect_valid) begin
            r_fpc <= redirect_pc;
            if (r_state == WAIT && !w_ack) begin
                r_state     <= DROP;
                r_drop_addr <= r_fpc;
            end else if (r_state != DROP || w_ack)
                r_state <= halt ? IDLE : WAIT;
        end else begin
            case (r_state)
                IDLE: if (!halt && w_count < CW'(DEPTH)) r_state <= WAIT;
                WAIT: if (w_ack) begin
                    r_fpc   <= pc_inc(r_fpc);
                    r_state <= (!halt && w_room) ? WAIT : IDLE;
                end
                DROP: if (w_ack) r_state <= halt ? IDLE : WAIT;
                default: r_state <= IDLE;
            endcase
        end
endmodule
